// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiply-add inverse (divider) block.
//   MULT_W      default operand width
//   mi_state_t  controller states of mult_inverse
//   mi_err_t    error codes reported on mult_inverse.err
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SUB  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } mi_state_t;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_DIV0  = 2'b01,
        ERR_UNDER = 2'b10,
        ERR_OVF   = 2'b11
    } mi_err_t;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   r       in   W   current partial remainder (always < b)
//   bit_in  in   1   next dividend bit shifted into the remainder
//   b       in   W   divisor
//   r_next  out  W   partial remainder after the step
//   q_bit   out  1   quotient bit produced by the step
// ---------------------------------------------------------------------------
module div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] r,
    input  logic         bit_in,
    input  logic [W-1:0] b,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    logic [W:0] t;

    assign t     = {r, bit_in};
    assign q_bit = (t >= {1'b0, b});

    // Since r < b, the restored value t - b is below b and fits in W bits,
    // so the subtraction can be done modulo 2^W on the low bits only.
    assign r_next = q_bit ? (t[W-1:0] - b) : t[W-1:0];

endmodule

// File: rtl/mult_inverse.sv
// ---------------------------------------------------------------------------
// mult_inverse
// Recovers A and the remainder from a multiply-add result data_in = A*B + C:
//   a_out = (data_in - c) / b,  rem_out = (data_in - c) mod b
// using a W-step sequential restoring divider.
//   clk      in   1    system clock, rising edge
//   rst_n    in   1    asynchronous active-low reset
//   start    in   1    request, sampled only in IDLE
//   data_in  in   2W   multiply-add result to decode
//   b        in   W    divisor (B operand)
//   c        in   W    addend to remove
//   a_out    out  W    recovered quotient
//   rem_out  out  W    remainder
//   err      out  2    00 ok, 01 b==0, 10 data_in<c, 11 quotient overflow
//   valid    out  1    one-cycle result strobe
//   busy     out  1    high whenever not idle
// ---------------------------------------------------------------------------
module mult_inverse
    import mult_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] data_in,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   c,
    output logic [W-1:0]   a_out,
    output logic [W-1:0]   rem_out,
    output logic [1:0]     err,
    output logic           valid,
    output logic           busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    mi_state_t      state;
    mi_state_t      state_n;
    logic [2*W-1:0] d_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   c_reg;
    logic [W-1:0]   r_reg;
    logic [W-1:0]   q_reg;
    logic [CW-1:0]  cnt;

    logic [2*W-1:0] n;
    mi_err_t        sub_err;
    logic [W-1:0]   step_r;
    logic           step_q;
    logic           last_step;

    assign n         = d_reg - {{W{1'b0}}, c_reg};
    assign last_step = (cnt == CW'(W - 1));

    // Error classification in priority order. A high half of N that is not
    // below b would need more than W quotient bits, and also would break
    // the R < b invariant the divider step relies on.
    always_comb begin
        sub_err = ERR_OK;
        if (b_reg == '0) begin
            sub_err = ERR_DIV0;
        end else if (d_reg < {{W{1'b0}}, c_reg}) begin
            sub_err = ERR_UNDER;
        end else if (n[2*W-1:W] >= b_reg) begin
            sub_err = ERR_OVF;
        end
    end

    // The dividend's bits are consumed MSB-first from the top of q_reg while
    // the quotient bits fill in from the bottom.
    div_step #(.W(W)) u_step (
        .r      (r_reg),
        .bit_in (q_reg[W-1]),
        .b      (b_reg),
        .r_next (step_r),
        .q_bit  (step_q)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = SUB;
            SUB:  state_n = (sub_err != ERR_OK) ? DONE : DIV;
            DIV:  if (last_step) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // valid and busy are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            d_reg   <= '0;
            b_reg   <= '0;
            c_reg   <= '0;
            r_reg   <= '0;
            q_reg   <= '0;
            cnt     <= '0;
            a_out   <= '0;
            rem_out <= '0;
            err     <= ERR_OK;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state <= state_n;
            valid <= (state_n == DONE);
            busy  <= (state_n != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        d_reg <= data_in;
                        b_reg <= b;
                        c_reg <= c;
                    end
                end
                SUB: begin
                    if (sub_err != ERR_OK) begin
                        err     <= sub_err;
                        a_out   <= (sub_err == ERR_OVF) ? '1 : '0;
                        rem_out <= '0;
                    end else begin
                        r_reg <= n[2*W-1:W];
                        q_reg <= n[W-1:0];
                        cnt   <= '0;
                    end
                end
                DIV: begin
                    r_reg <= step_r;
                    q_reg <= {q_reg[W-2:0], step_q};
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        a_out   <= {q_reg[W-2:0], step_q};
                        rem_out <= step_r;
                        err     <= ERR_OK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_inverse.sv
// ---------------------------------------------------------------------------
// tb_mult_inverse
// Scoreboard bench for mult_inverse: requests push the expected result into
// a queue, and a negedge monitor pops and compares on every valid pulse.
// ---------------------------------------------------------------------------
module tb_mult_inverse;
    import mult_pkg::*;

    localparam int W = MULT_W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2*W-1:0] data_in = '0;
    logic [W-1:0]   b = '0;
    logic [W-1:0]   c = '0;
    logic [W-1:0]   a_out;
    logic [W-1:0]   rem_out;
    logic [1:0]     err;
    logic           valid;
    logic           busy;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] rem;
        logic [1:0]   err;
        int           valid_edge;
        int           issue_cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    mult_inverse #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .b       (b),
        .c       (c),
        .a_out   (a_out),
        .rem_out (rem_out),
        .err     (err),
        .valid   (valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division of (data_in - c) by b, with the
    // error cases classified by value rather than by bit slices.
    function automatic exp_t refModel(input int d, input int bv, input int cv);
        exp_t e;
        int   nv;
        int   q;
        e.issue_cyc = 0;
        e.a   = '0;
        e.rem = '0;
        if (bv == 0) begin
            e.err = 2'b01;
        end else if (d < cv) begin
            e.err = 2'b10;
        end else begin
            nv = d - cv;
            q  = nv / bv;
            if (q > (1 << W) - 1) begin
                e.err = 2'b11;
                e.a   = '1;
            end else begin
                e.err = 2'b00;
                e.a   = W'(q);
                e.rem = W'(nv % bv);
            end
        end
        e.valid_edge = (e.err == 2'b00) ? W + 1 : 1;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Leaves the caller on a falling edge with the DUT idle (or after a
    // bounded wait that is reported as a failure).
    task automatic waitIdle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        total++;
        bad++;
        $display("[TB] FAIL wait_idle: busy stuck at %0d expected 0", busy);
    endtask

    task automatic applyStimulus(input int d, input int bv, input int cv);
        exp_t e;
        waitIdle();
        start   = 1'b1;
        data_in = (2*W)'(d);
        b       = W'(bv);
        c       = W'(cv);
        @(posedge clk);
        e = refModel(d, bv, cv);
        e.issue_cyc = cyc;
        sbq.push_back(e);
        #1;
        start   = 1'b0;
        data_in = (2*W)'($urandom);
        b       = W'($urandom);
        c       = W'($urandom);
    endtask

    // Monitor: every valid must match the oldest outstanding request, at the
    // expected edge; busy must stay high while anything is outstanding.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_valid: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("a_out", 32'(a_out), 32'(e.a));
                    checkOutput("rem_out", 32'(rem_out), 32'(e.rem));
                    checkOutput("err", 32'(err), 32'(e.err));
                    checkOutput("valid_edge", 32'(cyc - e.issue_cyc - 1), 32'(e.valid_edge));
                end
            end else if (sbq.size() != 0) begin
                checkOutput("busy", 32'(busy), 32'd1);
            end
        end
    end

    initial begin
        int bv;
        int av;
        int rv;
        int cv;
        int dv;

        // Reset values while held in reset.
        repeat (2) @(negedge clk);
        checkOutput("reset_a_out", 32'(a_out), 32'd0);
        checkOutput("reset_rem_out", 32'(rem_out), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        applyStimulus(96, 7, 5);
        applyStimulus(100, 7, 5);
        applyStimulus(65280, 255, 255);
        applyStimulus(1234, 0, 17);
        applyStimulus(3, 4, 5);
        applyStimulus(65535, 1, 0);
        applyStimulus(200, 1, 0);
        applyStimulus(255, 1, 0);

        // A start pulse in the middle of a division is dropped.
        applyStimulus(96, 7, 5);
        repeat (3) @(negedge clk);
        start   = 1'b1;
        data_in = 16'd1000;
        b       = 8'd3;
        c       = 8'd0;
        @(negedge clk);
        start = 1'b0;

        // A start pulse during the DONE cycle is dropped.
        applyStimulus(100, 7, 5);
        repeat (10) @(negedge clk);
        start   = 1'b1;
        data_in = 16'd500;
        b       = 8'd9;
        @(negedge clk);
        start = 1'b0;

        // Randomized requests, mostly built as A*B + R + C.
        for (int i = 0; i < 40; i++) begin
            bv = $urandom_range(0, 255);
            if ($urandom_range(0, 9) == 0) bv = 0;
            cv = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) begin
                dv = $urandom_range(0, 65535);
            end else begin
                av = $urandom_range(0, 255);
                rv = (bv > 0) ? $urandom_range(0, bv - 1) : 0;
                dv = (av * bv + rv + cv) & 16'hFFFF;
            end
            applyStimulus(dv, bv, cv);
        end

        // Abort an operation mid-division: outputs clear at once and the
        // aborted request never produces a valid.
        applyStimulus(96, 7, 5);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sbq.delete();
        checkOutput("abort_a_out", 32'(a_out), 32'd0);
        checkOutput("abort_rem_out", 32'(rem_out), 32'd0);
        checkOutput("abort_err", 32'(err), 32'd0);
        checkOutput("abort_valid", 32'(valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(96, 7, 5);

        // Drain the scoreboard within a bounded window, then watch for strays.
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: outstanding %0d expected 0", sbq.size());
        end
        repeat (15) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
